// File: rtl/toycpu_sequencer_if.sv
// Instruction/data memory handshake bundle for the toycpu sequencer.
// Requests are held by the sequencer until the memory side acks.
interface toycpu_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic mem_we;

    modport master (
        output imem_req,
        output dmem_req,
        output mem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  mem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/toycpu_sequencer.sv
// Multi-cycle control FSM for toycpu: fetch, decode, exec, mem, write-back.
// Gates decoder write enables to a single commit cycle; sticky fault on errors.
module toycpu_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step,
    input  logic [2:0]            opcode,
    input  logic                  dec_reg_we,
    input  logic                  dec_mem_we,
    toycpu_sequencer_if.master    bus,
    output logic                  ir_load,
    output logic                  reg_we,
    output logic                  pc_we,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      instr_count
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seqState_t;

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    seqState_t curState;
    seqState_t nxtState;
    logic [7:0] waitCnt;
    logic [7:0] waitNxt;
    logic [7:0] waitInc;
    logic faultQ;
    logic faultSet;
    logic retire;
    logic [CNT_W-1:0] instrCnt;

    logic isAlu;
    logic isMem;
    logic isBr;
    logic isSt;
    logic isIllegal;

    assign isAlu     = (opcode == 3'b000) || (opcode == 3'b001);
    assign isMem     = (opcode == 3'b011) || (opcode == 3'b101);
    assign isBr      = (opcode == 3'b110);
    assign isSt      = (opcode == 3'b101);
    assign isIllegal = !(isAlu || isMem || isBr);
    assign waitInc   = waitCnt + 8'd1;

    always_comb begin
        nxtState     = curState;
        waitNxt      = waitCnt;
        faultSet     = 1'b0;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        ir_load      = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        unique case (curState)
            IDLE: begin
                if (run || step) begin
                    nxtState = FETCH;
                    waitNxt  = 8'd0;
                end
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_load  = 1'b1;
                    nxtState = DECODE;
                end else if (waitInc == LIMIT) begin
                    nxtState = HALT;
                    faultSet = 1'b1;
                end else begin
                    waitNxt = waitInc;
                end
            end
            DECODE: begin
                if (isIllegal) begin
                    nxtState = HALT;
                    faultSet = 1'b1;
                end else begin
                    nxtState = EXEC;
                end
            end
            EXEC: begin
                unique case (1'b1)
                    isAlu: nxtState = WB;
                    isMem: begin
                        nxtState = MEM;
                        waitNxt  = 8'd0;
                    end
                    isBr: begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    default: begin
                        nxtState = HALT;
                        faultSet = 1'b1;
                    end
                endcase
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    if (isSt) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        nxtState = WB;
                    end
                end else if (waitInc == LIMIT) begin
                    nxtState = HALT;
                    faultSet = 1'b1;
                end else begin
                    waitNxt = waitInc;
                end
            end
            WB: begin
                reg_we = dec_reg_we;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            HALT: nxtState = HALT;
            default: nxtState = IDLE;
        endcase
        // Retiring re-enters FETCH directly in run mode, so clear the wait count.
        if (retire) begin
            nxtState = run ? FETCH : IDLE;
            waitNxt  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curState <= IDLE;
            waitCnt  <= 8'd0;
            faultQ   <= 1'b0;
            instrCnt <= '0;
        end else begin
            curState <= nxtState;
            waitCnt  <= waitNxt;
            faultQ   <= faultQ | faultSet;
            if (retire) begin
                instrCnt <= instrCnt + CNT_W'(1);
            end
        end
    end

    assign bus.mem_we  = bus.dmem_req & dec_mem_we;
    assign halted      = (curState == HALT);
    assign fault       = faultQ;
    assign state       = curState;
    assign instr_count = instrCnt;
endmodule
